// File: rtl/dm_pipe_pkg.sv
// Shared definitions for the pipelined data memory: access-type codes,
// lane geometry, pipeline stage record and request legality helpers.
package dm_pipe_pkg;

   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dm_type_e;

   localparam int LANE_OFS_W = 2;
   localparam int BYTE_LANES = 4;

   // One pipeline slot; the final slot drives the response port directly.
   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [2:0]            typ;
      logic [LANE_OFS_W-1:0] ofs;
      logic                  fault;
      logic [31:0]           word;
   } dm_stage_t;

   function automatic logic dm_type_legal(input logic [2:0] t);
      return (t <= 3'b100);
   endfunction

   // Word needs a 4-byte boundary, halfwords a 2-byte boundary.
   function automatic logic dm_misaligned(input logic [2:0] t,
                                          input logic [LANE_OFS_W-1:0] ofs);
      logic mis;
      mis = 1'b0;
      case (t)
         DM_WORD:            mis = (ofs != 2'b00);
         DM_HALF, DM_HALF_U: mis = ofs[0];
         default:            mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_pipe_lane_align.sv
// Byte-lane steering between a 32-bit memory word and a sub-word access.
// STORE_MODE=0: select the addressed lane of i_data and extend it.
// STORE_MODE=1: replicate right-justified i_data across lanes and
//               produce the matching byte enable.
module dm_lane_align
   import dm_pipe_pkg::*;
#(
   parameter bit STORE_MODE = 1'b0
) (
   input  logic [31:0]           i_data,
   input  logic [2:0]            i_type,
   input  logic [LANE_OFS_W-1:0] i_ofs,
   output logic [31:0]           o_data,
   output logic [BYTE_LANES-1:0] o_be
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword out of the word (load direction).
   always_comb begin
      w_byte = i_data[7:0];
      case (i_ofs)
         2'd0: w_byte = i_data[7:0];
         2'd1: w_byte = i_data[15:8];
         2'd2: w_byte = i_data[23:16];
         2'd3: w_byte = i_data[31:24];
         default: w_byte = i_data[7:0];
      endcase
      w_half = i_ofs[1] ? i_data[31:16] : i_data[15:0];
   end

   // Extension for loads, lane replication and byte enables for stores.
   always_comb begin
      o_data = '0;
      o_be   = '0;
      case (i_type)
         DM_WORD: begin
            o_data = i_data;
            o_be   = 4'b1111;
         end
         DM_HALF, DM_HALF_U: begin
            o_be = i_ofs[1] ? 4'b1100 : 4'b0011;
            if (STORE_MODE)
               o_data = {2{i_data[15:0]}};
            else if (i_type == DM_HALF)
               o_data = {{16{w_half[15]}}, w_half};
            else
               o_data = {16'h0000, w_half};
         end
         DM_BYTE, DM_BYTE_U: begin
            o_be = 4'b0001 << i_ofs;
            if (STORE_MODE)
               o_data = {4{i_data[7:0]}};
            else if (i_type == DM_BYTE)
               o_data = {{24{w_byte[7]}}, w_byte};
            else
               o_data = {24'h000000, w_byte};
         end
         default: begin
            o_data = '0;
            o_be   = '0;
         end
      endcase
   end

endmodule

// File: rtl/dm_pipe.sv
// Pipelined data memory for the CPU MEM stage. Requests are accepted with a
// valid/ready handshake; stores commit at the accept edge, loads read the
// word at the accept edge and travel READ_LAT register stages before the
// response. A stalled response freezes the whole pipe and the input side.
module dm_pipe
   import dm_pipe_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 32,
   parameter int READ_LAT    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   input  logic [2:0]        i_req_type,
   input  logic [31:0]       i_req_pc,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_fault,
   output logic [ADDR_W-1:0] o_fault_addr,
   output logic [31:0]       o_fault_pc,
   output logic [7:0]        o_fault_cnt
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]           r_mem [DEPTH_WORDS];
   dm_stage_t             r_stg [READ_LAT];
   logic [ADDR_W-1:0]     r_fault_addr;
   logic [31:0]           r_fault_pc;
   logic [7:0]            r_fault_cnt;

   dm_stage_t             w_last;
   logic                  w_stall;
   logic                  w_accept;
   logic                  w_range_err;
   logic                  w_fault;
   logic [IDX_W-1:0]      w_idx;
   logic [LANE_OFS_W-1:0] w_ofs;
   logic [31:0]           w_st_data;
   logic [BYTE_LANES-1:0] w_st_be;
   logic [31:0]           w_ld_data;
   logic [BYTE_LANES-1:0] w_ld_be_unused;

   assign w_idx = i_req_addr[IDX_W+1:2];
   assign w_ofs = i_req_addr[1:0];

   // Depth is a power of two, so any set bit above the index is out of range.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_range
         assign w_range_err = |i_req_addr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_range
         assign w_range_err = 1'b0;
      end
   endgenerate

   assign w_fault = w_range_err
                  | ~dm_type_legal(i_req_type)
                  | dm_misaligned(i_req_type, w_ofs);

   assign w_last      = r_stg[READ_LAT-1];
   assign w_stall     = w_last.valid && !i_rsp_ready;
   assign o_req_ready = !i_rst && !w_stall;
   assign w_accept    = i_req_valid && o_req_ready;

   dm_lane_align #(.STORE_MODE(1'b1)) u_st_align (
      .i_data (i_req_wdata),
      .i_type (i_req_type),
      .i_ofs  (w_ofs),
      .o_data (w_st_data),
      .o_be   (w_st_be)
   );

   dm_lane_align #(.STORE_MODE(1'b0)) u_ld_align (
      .i_data (w_last.word),
      .i_type (w_last.typ),
      .i_ofs  (w_last.ofs),
      .o_data (w_ld_data),
      .o_be   (w_ld_be_unused)
   );

   // Byte-enabled store commit at the accept edge; array is not reset.
   always_ff @(posedge i_clk) begin
      if (w_accept && i_req_we && !w_fault) begin
         for (int b = 0; b < BYTE_LANES; b++) begin
            if (w_st_be[b])
               r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
         end
      end
   end

   // Request pipeline: stage 0 captures the request and the old array word
   // (a store in the previous cycle has already committed), later stages shift.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < READ_LAT; i++)
            r_stg[i] <= '0;
      end else if (!w_stall) begin
         r_stg[0].valid <= w_accept;
         r_stg[0].we    <= i_req_we;
         r_stg[0].typ   <= i_req_type;
         r_stg[0].ofs   <= w_ofs;
         r_stg[0].fault <= w_fault;
         r_stg[0].word  <= r_mem[w_idx];
         for (int i = 1; i < READ_LAT; i++)
            r_stg[i] <= r_stg[i-1];
      end
   end

   // Capture the most recent faulting request and count faults (saturating).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fault_addr <= '0;
         r_fault_pc   <= '0;
         r_fault_cnt  <= '0;
      end else if (w_accept && w_fault) begin
         r_fault_addr <= i_req_addr;
         r_fault_pc   <= i_req_pc;
         if (r_fault_cnt != 8'hFF)
            r_fault_cnt <= r_fault_cnt + 8'd1;
      end
   end

   // Response data is zero for stores, faults and idle slots.
   always_comb begin
      o_rsp_rdata = '0;
      if (w_last.valid && !w_last.we && !w_last.fault)
         o_rsp_rdata = w_ld_data;
   end

   assign o_rsp_valid  = w_last.valid;
   assign o_rsp_fault  = w_last.valid && w_last.fault;
   assign o_fault_addr = r_fault_addr;
   assign o_fault_pc   = r_fault_pc;
   assign o_fault_cnt  = r_fault_cnt;

endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
- Parametrised, pipelined data memory for the pipelined CPU MEM stage; successor to the single-cycle combinational-read data memory.
- Word-organised array with byte/halfword/word loads and stores, signed and unsigned, selected by the shared DMType codes.
- Adds a valid/ready request/response handshake, configurable registered read latency, and misalignment/range fault detection with a captured fault address.
- Responses stay in order.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- ADDR_W, 32: byte-address width.
- READ_LAT, 1: cycles from request accept to response; legal values 1..3.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_type  in  3  DMType code.
- req_pc  in  32  PC of the issuing instruction; debug/fault capture only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended per type; 0 for stores and faults.
- rsp_fault  out  1  request faulted.
- fault_addr  out  ADDR_W  byte address of the most recent fault.
- fault_pc  out  32  req_pc of the most recent fault.
- fault_cnt  out  8  saturating count of faults.

Behaviour:
- Reset (synchronous, active-high):
  - All response and fault outputs clear to 0: rsp_valid, rsp_rdata, rsp_fault, fault_addr, fault_pc, fault_cnt.
  - Pipeline valid bits clear.
  - req_ready = 0 while rst is high.
  - Array contents are not cleared by rst. Simulation initial contents are all zero.
- DMType codes:
  - word = 3'b000, halfword = 3'b001, halfword_unsigned = 3'b010, byte = 3'b011, byte_unsigned = 3'b100.
  - Codes 3'b101..3'b111 are illegal and fault.
- Fault check (combinational at accept):
  - Halfword types fault when addr[0] = 1.
  - Word faults when addr[1:0] != 0.
  - Any request faults when addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - Any request with an illegal type faults.
- Stores:
  - Commit at the accept edge, only if not faulted.
  - Byte-enable merge: byte at addr[1:0] gets wdata[7:0]; halfword at addr[1] gets wdata[15:0]; word replaces all 4 bytes. Untouched bytes keep their value.
  - A faulted store leaves the array unchanged.
- Loads:
  - The word is read at the accept edge into pipeline stage 1.
  - Lane select and extension use the same lane rules as stores. Signed types sign-extend from bit 7 or bit 15; unsigned types zero-extend.
  - A load accepted the cycle after a store to the same word returns the new data. No forwarding path is needed because the store commits first.
- Every accepted request (load or store, faulted or not) produces exactly one response, READ_LAT cycles after accept when not stalled.
- Pipeline:
  - READ_LAT stages shift together.
  - Stall condition: rsp_valid && !rsp_ready. While stalled, all stages hold and req_ready = 0.
  - Otherwise req_ready = 1, so one request per cycle is accepted at full throughput.
  - Outputs stay stable while stalled.
  - Stage contents: valid, we, type, addr[1:0], fault, raw word. The final stage is registered.
- Fault capture:
  - On accept of a faulting request, fault_addr and fault_pc load in the same cycle.
  - fault_cnt increments and saturates at 255.
  - rsp_fault = 1 is delivered with that request's response.
- rst mid-operation: in-flight responses are discarded and no response is emitted for them. Stores already committed remain in the array.
- Debug: $display of the PC, byte address and the written word on each committed store.

Decomposition:
- Shared package/include (extend ctrl_encode_def.v):
  - The five DMType codes.
  - Localparams for lane-select widths.
- Sub-module dm_lane_align, purely combinational, used twice:
  - Load mode: word, type, offset -> extended data.
  - Store mode: wdata, type, offset -> 4-bit byte enable and lane-shifted write data.
- The array, pipeline registers, handshake and fault logic live in dm_pipe.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, fault_cnt=0; no response follows release.
- Byte store/load: store byte 0xA5 at addr 0x13 over word 0x11223344 at 0x10, then load byte and byte_unsigned from 0x13 -> word becomes 0xA5223344; rsp_rdata = 0xFFFFFFA5, then 0x000000A5.
- Back-to-back halfword: store halfword 0x8001 at 0x22, immediately load halfword from 0x22 (READ_LAT=2) -> response 2 cycles after accept, rsp_rdata = 0xFFFF8001, no bubbles.
- Misaligned store: word store to 0x41 with pc 0x100 -> rsp_fault=1, fault_addr=0x41, fault_pc=0x100, fault_cnt=1; word at 0x40 unchanged.
- Out of range: load from address 4*DEPTH_WORDS -> rsp_fault=1, rsp_rdata=0.
- Backpressure: 4 loads issued while rsp_ready=0 -> req_ready drops once rsp_valid rises and the first response is held; release rsp_ready -> 4 responses in order with correct data, none lost or duplicated.
